time_entry_sequencer: RTL and testbench
=======================================

Name: time_entry_sequencer

Overview:
- Controller for the keypad time-entry datapath: the decimal-to-binary encoder feeding three 2-digit shift registers (hour, min, sec).
- Detects key-press edges, pulses the per-field shift enables and validates each field on '#'.
- Steps hour -> min -> sec, then signals completeSetting to the alarm/clock core.
- Adds field clear, error reporting, timeout and abort, which the plain enable sequencer lacks.

Parameters:
- TIMEOUT_CYCLES, 1000: idle clock cycles in an entry state before the session aborts (must be >= 2).
- TO_W, 16: width of the timeout counter (2^TO_W > TIMEOUT_CYCLES).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- en  in  1  session request; a rising edge starts entry, deassertion aborts it.
- keypad  in  10  digit keys, one-hot; bit i = digit i.
- sharp  in  1  '#' key: confirm the current field.
- star  in  1  '*' key: clear the current field.
- digit  out  4  binary digit of the last accepted press; drives the shift register Din.
- hour_ce  out  1  one-cycle shift enable, hour register.
- min_ce  out  1  one-cycle shift enable, min register.
- sec_ce  out  1  one-cycle shift enable, sec register.
- field_clr  out  3  one-cycle clear pulses {sec, min, hour}.
- field  out  2  0 = hour, 1 = min, 2 = sec, 3 = idle.
- busy  out  1  high in the HOUR, MIN and SEC states.
- error  out  1  one-cycle pulse on a rejected confirm.
- abort  out  1  one-cycle pulse on timeout or en drop.
- completeSetting  out  1  one-cycle pulse when all three fields are valid.

Behaviour:
- Reset:
  - State goes to IDLE. All pulse outputs = 0, digit = 0, field = 3, busy = 0.
  - Edge-detect registers, digit count, mirrors and timeout counter are cleared.
  - rst mid-session is honoured on the next edge with no completeSetting or abort pulse.
- Edge detection (registered previous value of keypad, sharp, star and en):
  - A key press counts when the signal is nonzero now and was zero in the previous cycle.
  - A keypad press with more than one bit set is ignored.
- Priority when events arrive in the same cycle: star > sharp > digit. Lower-priority events in that cycle are dropped.
- Registered outputs: every response appears in cycle t+1 for an event sampled in cycle t.
- State machine: IDLE, HOUR, MIN, SEC, DONE.
  - IDLE -> HOUR on an en rising edge. field_clr = 3'b111 for 1 cycle; count and mirrors are cleared.
  - In HOUR, MIN and SEC:
    - Digit press: digit <= value; the current field's ce pulses for 1 cycle.
    - Mirror update: tens_m <= ones_m, ones_m <= value, matching the shift register (ten <= one, one <= Din).
    - count <= min(count + 1, 2). More than two digits keeps shifting, so the last two digits win.
  - Star: field_clr pulses for the current field only; count = 0 and mirrors = 0.
  - Sharp with count = 0: error pulse, stay in the current state.
  - Sharp, range check on value = tens_m*10 + ones_m:
    - HOUR is valid if value <= 23; MIN and SEC are valid if value <= 59.
    - Valid: advance HOUR -> MIN -> SEC -> DONE; count and mirrors are cleared.
    - Invalid: error pulse and field_clr pulse for the current field; count = 0; stay in the current state.
  - A single-digit entry is valid; it is read as 0d.
  - DONE: completeSetting = 1 for exactly 1 cycle, then IDLE. en must fall and rise again to restart.
- Timeout:
  - The counter clears on state entry and on every accepted event, and increments otherwise while busy.
  - Reaching TIMEOUT_CYCLES-1: abort pulse, go to IDLE. Field contents are untouched.
- en low while busy: abort pulse, go to IDLE. en has priority over key events in the same cycle.
- Outputs in IDLE and DONE: keys are ignored; no ce or clr pulses are produced.

Test Plan:
- Happy path: rst, then en rise; keys 1,2,#,3,4,#,5,6,#.
  - Response: clr = 111 once; two ce pulses per field with digit = 1,2 / 3,4 / 5,6; field steps 0,1,2.
  - completeSetting is a 1-cycle pulse; field = 3 afterwards.
- Invalid hour: keys 2,5,# in HOUR.
  - Response: error pulse, field_clr = 001, stays HOUR.
  - Then keys 2,3,# -> advances to MIN.
- Overflow and edge cases:
  - Keys 1,2,3,# in MIN -> value 23 is accepted.
  - '#' with no digits -> error pulse, state unchanged.
- Simultaneous press: star and digit 7 in the same cycle -> only a clr pulse, no ce.
  - keypad = 10'b0000000011 -> ignored.
- Timeout: TIMEOUT_CYCLES = 20, enter SEC and stay idle.
  - Response: abort pulse at cycle 19 after the last event; busy = 0.
- Abort and reset:
  - en drops mid-HOUR -> abort pulse, IDLE.
  - rst asserted in MIN -> next cycle all outputs at reset values, with no completeSetting or abort pulse.

Source files
------------

// File: rtl/time_entry_sequencer.sv
// Keypad time-entry controller: detects key edges, drives the hour/min/sec
// shift-register enables and clears, range-checks each field on '#', and
// reports completion, rejected confirms, timeouts and aborted sessions.
module time_entry_sequencer #(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int TO_W           = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [9:0] keypad,
  input  logic       sharp,
  input  logic       star,
  output logic [3:0] digit,
  output logic       hour_ce,
  output logic       min_ce,
  output logic       sec_ce,
  output logic [2:0] field_clr,
  output logic [1:0] field,
  output logic       busy,
  output logic       error,
  output logic       abort,
  output logic       completeSetting
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HOUR = 3'd1;
  localparam logic [2:0] S_MIN  = 3'd2;
  localparam logic [2:0] S_SEC  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  // The abort is issued on the edge where the idle count reaches TIMEOUT_CYCLES-1.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 2);

  logic [2:0]      state_reg, state_next;
  logic [9:0]      keypad_prev_reg;
  logic            sharp_prev_reg, star_prev_reg, en_prev_reg;
  logic [1:0]      count_reg, count_next;
  logic [3:0]      tens_reg, tens_next, ones_reg, ones_next;
  logic [TO_W-1:0] to_cnt_reg, to_cnt_next;
  logic [3:0]      digit_reg, digit_next;
  logic [2:0]      ce_reg, ce_next;
  logic [2:0]      clr_reg, clr_next;
  logic            error_reg, error_next;
  logic            abort_reg, abort_next;
  logic            complete_reg, complete_next;

  logic            key_press, sharp_rise, star_rise, en_rise;
  logic [3:0]      key_val;
  logic [6:0]      value;
  logic [6:0]      limit;
  logic [2:0]      cur_sel;

  // Rising-edge detection; a multi-key keypad press is discarded.
  always_comb begin
    key_val = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (keypad[i]) key_val = 4'(i);
    end
  end

  assign key_press  = (keypad != 10'd0) && (keypad_prev_reg == 10'd0) &&
                      ((keypad & (keypad - 10'd1)) == 10'd0);
  assign sharp_rise = sharp && !sharp_prev_reg;
  assign star_rise  = star && !star_prev_reg;
  assign en_rise    = en && !en_prev_reg;

  assign value   = ({3'd0, tens_reg} * 7'd10) + {3'd0, ones_reg};
  assign limit   = (state_reg == S_HOUR) ? 7'd23 : 7'd59;
  assign cur_sel = (state_reg == S_HOUR) ? 3'b001 :
                   (state_reg == S_MIN)  ? 3'b010 :
                   (state_reg == S_SEC)  ? 3'b100 : 3'b000;

  // Next-state and response logic; priority is en drop > star > sharp > digit > timeout.
  always_comb begin
    state_next    = state_reg;
    count_next    = count_reg;
    tens_next     = tens_reg;
    ones_next     = ones_reg;
    to_cnt_next   = to_cnt_reg;
    digit_next    = digit_reg;
    ce_next       = 3'b000;
    clr_next      = 3'b000;
    error_next    = 1'b0;
    abort_next    = 1'b0;
    complete_next = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (en_rise) begin
          state_next  = S_HOUR;
          clr_next    = 3'b111;
          count_next  = 2'd0;
          tens_next   = 4'd0;
          ones_next   = 4'd0;
          to_cnt_next = '0;
        end
      end
      S_HOUR, S_MIN, S_SEC: begin
        if (!en) begin
          abort_next  = 1'b1;
          state_next  = S_IDLE;
          to_cnt_next = '0;
        end else if (star_rise) begin
          clr_next    = cur_sel;
          count_next  = 2'd0;
          tens_next   = 4'd0;
          ones_next   = 4'd0;
          to_cnt_next = '0;
        end else if (sharp_rise) begin
          to_cnt_next = '0;
          if (count_reg == 2'd0) begin
            error_next = 1'b1;
          end else begin
            count_next = 2'd0;
            tens_next  = 4'd0;
            ones_next  = 4'd0;
            if (value <= limit) begin
              state_next = (state_reg == S_HOUR) ? S_MIN :
                           (state_reg == S_MIN)  ? S_SEC : S_DONE;
            end else begin
              error_next = 1'b1;
              clr_next   = cur_sel;
            end
          end
        end else if (key_press) begin
          digit_next  = key_val;
          ce_next     = cur_sel;
          tens_next   = ones_reg;
          ones_next   = key_val;
          count_next  = (count_reg == 2'd2) ? 2'd2 : count_reg + 2'd1;
          to_cnt_next = '0;
        end else if (to_cnt_reg == TO_LAST) begin
          abort_next  = 1'b1;
          state_next  = S_IDLE;
          to_cnt_next = '0;
        end else begin
          to_cnt_next = to_cnt_reg + 1'b1;
        end
      end
      S_DONE: begin
        complete_next = 1'b1;
        state_next    = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // State, edge-detect history and registered output pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= S_IDLE;
      keypad_prev_reg <= 10'd0;
      sharp_prev_reg  <= 1'b0;
      star_prev_reg   <= 1'b0;
      en_prev_reg     <= 1'b0;
      count_reg       <= 2'd0;
      tens_reg        <= 4'd0;
      ones_reg        <= 4'd0;
      to_cnt_reg      <= '0;
      digit_reg       <= 4'd0;
      ce_reg          <= 3'b000;
      clr_reg         <= 3'b000;
      error_reg       <= 1'b0;
      abort_reg       <= 1'b0;
      complete_reg    <= 1'b0;
    end else begin
      state_reg       <= state_next;
      keypad_prev_reg <= keypad;
      sharp_prev_reg  <= sharp;
      star_prev_reg   <= star;
      en_prev_reg     <= en;
      count_reg       <= count_next;
      tens_reg        <= tens_next;
      ones_reg        <= ones_next;
      to_cnt_reg      <= to_cnt_next;
      digit_reg       <= digit_next;
      ce_reg          <= ce_next;
      clr_reg         <= clr_next;
      error_reg       <= error_next;
      abort_reg       <= abort_next;
      complete_reg    <= complete_next;
    end
  end

  assign digit           = digit_reg;
  assign hour_ce         = ce_reg[0];
  assign min_ce          = ce_reg[1];
  assign sec_ce          = ce_reg[2];
  assign field_clr       = clr_reg;
  assign error           = error_reg;
  assign abort           = abort_reg;
  assign completeSetting = complete_reg;
  assign busy            = (state_reg == S_HOUR) || (state_reg == S_MIN) || (state_reg == S_SEC);
  assign field           = (state_reg == S_HOUR) ? 2'd0 :
                           (state_reg == S_MIN)  ? 2'd1 :
                           (state_reg == S_SEC)  ? 2'd2 : 2'd3;

endmodule

// File: tb/tb_time_entry_sequencer.sv
// Bench for time_entry_sequencer: every driven cycle pushes the expected
// output word to a scoreboard queue, which is popped and compared after the edge.
module tb_time_entry_sequencer;

  localparam int TO = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [9:0] keypad = 10'd0;
  logic       sharp = 1'b0;
  logic       star = 1'b0;
  logic [3:0] digit;
  logic       hour_ce, min_ce, sec_ce;
  logic [2:0] field_clr;
  logic [1:0] field;
  logic       busy, error, abort, completeSetting;

  time_entry_sequencer #(.TIMEOUT_CYCLES(TO), .TO_W(16)) dut (
    .clk(clk), .rst(rst), .en(en), .keypad(keypad), .sharp(sharp), .star(star),
    .digit(digit), .hour_ce(hour_ce), .min_ce(min_ce), .sec_ce(sec_ce),
    .field_clr(field_clr), .field(field), .busy(busy), .error(error),
    .abort(abort), .completeSetting(completeSetting)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] exp_q[$];
  logic [3:0]  dg;
  logic [1:0]  fld;

  wire [15:0] obs = {digit, sec_ce, min_ce, hour_ce, field_clr, field,
                     busy, error, abort, completeSetting};

  // Packed word {digit, ce{sec,min,hour}, clr, field, busy, error, abort, complete}.
  function automatic logic [15:0] mk(logic [3:0] d, logic [2:0] ce, logic [2:0] clr,
                                     logic [1:0] f, logic b, logic e, logic a, logic c);
    return {d, ce, clr, f, b, e, a, c};
  endfunction

  function automatic logic [2:0] sel(logic [1:0] f);
    return (f == 2'd3) ? 3'b000 : (3'b001 << f);
  endfunction

  task automatic check(string tag, logic [15:0] got, logic [15:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", tag, got, want);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic step(string tag, logic [9:0] kp, logic sh, logic st, logic [15:0] want);
    logic [15:0] w;
    keypad = kp;
    sharp  = sh;
    star   = st;
    exp_q.push_back(want);
    @(posedge clk);
    #1;
    w = exp_q.pop_front();
    check(tag, obs, w);
  endtask

  task automatic quiet(string tag);
    step(tag, 10'd0, 1'b0, 1'b0, mk(dg, 3'b000, 3'b000, fld, fld != 2'd3, 1'b0, 1'b0, 1'b0));
  endtask

  task automatic key(int d);
    dg = 4'(d);
    step($sformatf("key%0d_f%0d", d, fld), 10'd1 << d, 1'b0, 1'b0,
         mk(dg, sel(fld), 3'b000, fld, 1'b1, 1'b0, 1'b0, 1'b0));
    quiet("release");
  endtask

  task automatic confirm_ok();
    fld = (fld == 2'd2) ? 2'd3 : fld + 2'd1;
    step("sharp_ok", 10'd0, 1'b1, 1'b0, mk(dg, 3'b000, 3'b000, fld, fld != 2'd3, 1'b0, 1'b0, 1'b0));
    if (fld == 2'd3) begin
      step("complete", 10'd0, 1'b0, 1'b0, mk(dg, 3'b000, 3'b000, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1));
      quiet("after_complete");
    end else begin
      quiet("release");
    end
  endtask

  task automatic confirm_err(logic with_clr);
    step("sharp_err", 10'd0, 1'b1, 1'b0,
         mk(dg, 3'b000, with_clr ? sel(fld) : 3'b000, fld, 1'b1, 1'b1, 1'b0, 1'b0));
    quiet("release");
  endtask

  task automatic start();
    en = 1'b0;
    quiet("en_low");
    en = 1'b1;
    fld = 2'd0;
    step("en_rise", 10'd0, 1'b0, 1'b0, mk(dg, 3'b000, 3'b111, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    dg  = 4'd0;
    fld = 2'd3;
    step("reset0", 10'd0, 1'b0, 1'b0, mk(4'd0, 3'b000, 3'b000, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0));
    step("reset1", 10'd0, 1'b0, 1'b0, mk(4'd0, 3'b000, 3'b000, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0));
    rst = 1'b0;

    // Happy path 12:34:56.
    start();
    key(1); key(2); confirm_ok();
    key(3); key(4); confirm_ok();
    key(5); key(6); confirm_ok();

    // Invalid hour, empty confirm, overflow digits, simultaneous and multi-key presses.
    start();
    key(2); key(5); confirm_err(1'b1);
    key(2); key(3); confirm_ok();
    confirm_err(1'b0);
    key(1); key(2); key(3); confirm_ok();
    step("star_key7", 10'd1 << 7, 1'b0, 1'b1, mk(dg, 3'b000, 3'b100, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0));
    quiet("release");
    step("multihot", 10'b0000000011, 1'b0, 1'b0, mk(dg, 3'b000, 3'b000, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0));
    quiet("release");
    key(6); key(0); confirm_err(1'b1);
    confirm_err(1'b0);
    key(5); key(9); confirm_ok();

    // Timeout in SEC: abort on the 19th edge after the confirming '#'.
    start();
    key(0); key(0); confirm_ok();
    key(5); confirm_ok();
    for (int i = 2; i <= TO - 2; i++) quiet("sec_idle");
    step("timeout", 10'd0, 1'b0, 1'b0, mk(dg, 3'b000, 3'b000, 2'd3, 1'b0, 1'b0, 1'b1, 1'b0));
    fld = 2'd3;
    quiet("after_timeout");

    // en drop mid-HOUR wins over a simultaneous digit press.
    start();
    key(1);
    en = 1'b0;
    step("en_drop", 10'd1 << 3, 1'b0, 1'b0, mk(dg, 3'b000, 3'b000, 2'd3, 1'b0, 1'b0, 1'b1, 1'b0));
    fld = 2'd3;

    // Reset in MIN returns everything to reset values without pulses.
    start();
    key(1); confirm_ok();
    key(4);
    rst = 1'b1;
    en  = 1'b0;
    step("rst_mid", 10'd1 << 5, 1'b0, 1'b0, mk(4'd0, 3'b000, 3'b000, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0));
    rst = 1'b0;
    dg  = 4'd0;
    fld = 2'd3;
    quiet("post_rst0");
    quiet("post_rst1");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
